btn_debounce: RTL

BTN_DEBOUNCE -- requirements
Module: btn_debounce

---
 rtl/btn_pkg.sv | 17 +
 rtl/btn_debounce_if.sv | 18 +
 rtl/btn_channel.sv | 136 +++++++++++++
 rtl/btn_debounce.sv | 57 +++++
 4 files changed

// File: rtl/btn_pkg.sv
// Shared constants and channel FSM state for the button debouncer.
package btn_pkg;

  localparam int N_CH_DEF         = 5;
  localparam int TICK_DIV_DEF     = 1250000;  // 40 Hz sample rate at 50 MHz
  localparam int STABLE_N_DEF     = 2;
  localparam int LONG_TICKS_DEF   = 40;
  localparam int REPEAT_TICKS_DEF = 8;
  localparam int ACTIVE_LOW_DEF   = 1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    HELD      = 2'd1,
    REPEATING = 2'd2
  } ch_state_t;

endpackage

// File: rtl/btn_debounce_if.sv
// Raw button pins in, debounced level and event pulses out.
interface btn_debounce_if
  import btn_pkg::*;
#(
  parameter int N_CH = N_CH_DEF
);

  logic [N_CH-1:0] BIN;
  logic [N_CH-1:0] LEVEL;
  logic [N_CH-1:0] PRESS;
  logic [N_CH-1:0] RELEASE;
  logic [N_CH-1:0] LONG;
  logic [N_CH-1:0] REPT;

  modport master (output BIN, input LEVEL, PRESS, RELEASE, LONG, REPT);
  modport slave  (input BIN, output LEVEL, PRESS, RELEASE, LONG, REPT);

endinterface

// File: rtl/btn_channel.sv
// One button: synchronizer, tick-sampled debounce, hold/repeat FSM, pulses.
module btn_channel
  import btn_pkg::*;
#(
  parameter int STABLE_N     = STABLE_N_DEF,
  parameter int LONG_TICKS   = LONG_TICKS_DEF,
  parameter int REPEAT_TICKS = REPEAT_TICKS_DEF,
  parameter int ACTIVE_LOW   = ACTIVE_LOW_DEF
) (
  input  logic CLK,
  input  logic RST,
  input  logic tick,
  input  logic bin,
  output logic level,
  output logic press,
  output logic rel,
  output logic long_p,
  output logic rept
);

  localparam int SW = $clog2(STABLE_N) + 1;
  localparam int HW = $clog2(LONG_TICKS) + 1;
  localparam int RW = $clog2(REPEAT_TICKS) + 1;

  // Raw pin value that means "not pressed"; the synchronizer resets to it
  // so a button held through reset is seen as a fresh press.
  localparam logic RELEASED = (ACTIVE_LOW != 0);

  localparam logic [SW-1:0] STABLE_LAST = SW'(STABLE_N - 1);
  localparam logic [HW-1:0] HOLD_LAST   = HW'(LONG_TICKS - 1);
  localparam logic [HW-1:0] HOLD_MAX    = HW'(LONG_TICKS);
  localparam logic [RW-1:0] REP_LAST    = RW'(REPEAT_TICKS - 1);

  logic          s0, s1;
  logic          sample;
  logic [SW-1:0] stable_cnt;
  logic [HW-1:0] hold_cnt;
  logic [RW-1:0] rep_cnt;
  logic          flip, rise, fall;
  ch_state_t     state;

  // Two-flop synchronizer for the asynchronous pin.
  always_ff @(posedge CLK) begin
    if (RST) begin
      s0 <= RELEASED;
      s1 <= RELEASED;
    end else begin
      s0 <= bin;
      s1 <= s0;
    end
  end

  assign sample = s1 ^ RELEASED;
  assign flip   = tick && (sample != level) && (stable_cnt == STABLE_LAST);
  assign rise   = flip & ~level;
  assign fall   = flip & level;

  // Debounce: level changes only after STABLE_N consecutive differing ticks.
  always_ff @(posedge CLK) begin
    if (RST) begin
      level      <= 1'b0;
      stable_cnt <= '0;
    end else if (tick) begin
      if (sample != level) begin
        if (stable_cnt == STABLE_LAST) begin
          level      <= ~level;
          stable_cnt <= '0;
        end else begin
          stable_cnt <= stable_cnt + 1'b1;
        end
      end else begin
        stable_cnt <= '0;
      end
    end
  end

  // Hold/repeat FSM; a release on a tick overrides any LONG/REPT due then.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      hold_cnt <= '0;
      rep_cnt  <= '0;
      press    <= 1'b0;
      rel      <= 1'b0;
      long_p   <= 1'b0;
      rept     <= 1'b0;
    end else begin
      press  <= 1'b0;
      rel    <= 1'b0;
      long_p <= 1'b0;
      rept   <= 1'b0;
      if (tick) begin
        if (fall) begin
          rel      <= 1'b1;
          state    <= IDLE;
          hold_cnt <= '0;
          rep_cnt  <= '0;
        end else begin
          case (state)
            IDLE: begin
              if (rise) begin
                press    <= 1'b1;
                rept     <= 1'b1;
                hold_cnt <= '0;
                state    <= HELD;
              end
            end
            HELD: begin
              if (hold_cnt == HOLD_LAST) begin
                long_p   <= 1'b1;
                rept     <= 1'b1;
                hold_cnt <= HOLD_MAX;
                rep_cnt  <= '0;
                state    <= REPEATING;
              end else if (hold_cnt != HOLD_MAX) begin
                hold_cnt <= hold_cnt + 1'b1;
              end
            end
            REPEATING: begin
              if (REPEAT_TICKS > 0) begin
                if (rep_cnt == REP_LAST) begin
                  rept    <= 1'b1;
                  rep_cnt <= '0;
                end else begin
                  rep_cnt <= rep_cnt + 1'b1;
                end
              end
            end
            default: state <= IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: rtl/btn_debounce.sv
// Multi-channel button debouncer: shared sample tick, one channel per pin.
module btn_debounce
  import btn_pkg::*;
#(
  parameter int N_CH         = N_CH_DEF,
  parameter int TICK_DIV     = TICK_DIV_DEF,
  parameter int STABLE_N     = STABLE_N_DEF,
  parameter int LONG_TICKS   = LONG_TICKS_DEF,
  parameter int REPEAT_TICKS = REPEAT_TICKS_DEF,
  parameter int ACTIVE_LOW   = ACTIVE_LOW_DEF
) (
  input  logic           CLK,
  input  logic           RST,
  btn_debounce_if.slave  bus
);

  localparam int TW = $clog2(TICK_DIV) + 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  logic [TW-1:0]   tick_cnt;
  logic            tick;
  logic [N_CH-1:0] level_v, press_v, rel_v, long_v, rept_v;

  assign tick = (tick_cnt == TICK_LAST);

  // Free-running sample-tick divider shared by all channels.
  always_ff @(posedge CLK) begin
    if (RST || tick) tick_cnt <= '0;
    else             tick_cnt <= tick_cnt + 1'b1;
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    btn_channel #(
      .STABLE_N     (STABLE_N),
      .LONG_TICKS   (LONG_TICKS),
      .REPEAT_TICKS (REPEAT_TICKS),
      .ACTIVE_LOW   (ACTIVE_LOW)
    ) u_ch (
      .CLK    (CLK),
      .RST    (RST),
      .tick   (tick),
      .bin    (bus.BIN[i]),
      .level  (level_v[i]),
      .press  (press_v[i]),
      .rel    (rel_v[i]),
      .long_p (long_v[i]),
      .rept   (rept_v[i])
    );
  end

  assign bus.LEVEL   = level_v;
  assign bus.PRESS   = press_v;
  assign bus.RELEASE = rel_v;
  assign bus.LONG    = long_v;
  assign bus.REPT    = rept_v;

endmodule
